// File: rtl/common_types_pkg.sv
// Shared types for the RAM arbiter: bus word, arbiter state encoding and RAM request payload.
package common_types_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned DEFAULT_LAT = 2;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2,
    DUMP = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic  ren;
    logic  wen;
    word_t addr;
    word_t store;
  } ram_req_t;

  // Counter preload so that an access spends exactly lat cycles in its state.
  function automatic logic [CNT_W-1:0] lat_preload(input int unsigned lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between CPU instruction/data ports and a dump port.
// Round-robin on CPU ties; the request is latched at grant and held for LAT cycles.
module ram_arbiter
  import common_types_pkg::*;
#(
  parameter int unsigned LAT = DEFAULT_LAT
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  iren,
  input  word_t iaddr,
  output logic  iwait,
  output word_t iload,
  input  logic  dren,
  input  logic  dwen,
  input  word_t daddr,
  input  word_t dstore,
  output logic  dwait,
  output word_t dload,
  input  logic  override_ctrl,
  input  logic  dump_ren,
  input  word_t dump_addr,
  output logic  dump_wait,
  output word_t dump_load,
  output logic  ram_ren,
  output logic  ram_wen,
  output word_t ram_addr,
  output word_t ram_store,
  input  word_t ram_load
);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_data_q, last_data_d;
  ram_req_t         req_q, req_d;

  logic i_pend, d_pend;
  logic done, i_done, d_done, dump_done;

  assign i_pend = iren;
  assign d_pend = dren | dwen;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_data_q <= 1'b0;
      req_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_data_q <= last_data_d;
      req_q       <= req_d;
    end
  end

  // Grant from IDLE; access states count down and fall back to IDLE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_data_d = last_data_q;
    req_d       = req_q;
    case (state_q)
      IDLE: begin
        req_d = '0;
        if (override_ctrl) begin
          if (dump_ren) begin
            state_d    = DUMP;
            cnt_d      = lat_preload(LAT);
            req_d.ren  = 1'b1;
            req_d.addr = dump_addr;
          end
        end else if (d_pend && (!i_pend || !last_data_q)) begin
          state_d     = DACC;
          cnt_d       = lat_preload(LAT);
          last_data_d = 1'b1;
          req_d.ren   = ~dwen;
          req_d.wen   = dwen;
          req_d.addr  = daddr;
          req_d.store = dstore;
        end else if (i_pend) begin
          state_d     = IACC;
          cnt_d       = lat_preload(LAT);
          last_data_d = 1'b0;
          req_d.ren   = 1'b1;
          req_d.addr  = iaddr;
        end
      end
      default: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          req_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
  end

  assign done      = (state_q != IDLE) && (cnt_q == '0);
  assign i_done    = done && (state_q == IACC);
  assign d_done    = done && (state_q == DACC);
  assign dump_done = done && (state_q == DUMP);

  // Completion is combinational; data is dropped if the requester has gone away.
  assign iwait     = iren & ~i_done;
  assign dwait     = d_pend & ~d_done;
  assign dump_wait = dump_ren & ~dump_done;

  assign iload     = (i_done && iren) ? ram_load : '0;
  assign dload     = (d_done && dren && req_q.ren) ? ram_load : '0;
  assign dump_load = (dump_done && dump_ren) ? ram_load : '0;

  assign ram_ren   = req_q.ren;
  assign ram_wen   = req_q.wen;
  assign ram_addr  = req_q.addr;
  assign ram_store = req_q.store;

endmodule
